// File: rtl/fetch_pc_pkg.sv
// fetch_pc_pkg: shared state encoding, default vectors and redirect priority for the fetch PC.
package fetch_pc_pkg;
  typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2} state_e;
  typedef enum logic [1:0] {RD_NONE = 2'd0, RD_EXC = 2'd1, RD_ERET = 2'd2, RD_BR = 2'd3} redir_e;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;
  function automatic redir_e redir_sel(input logic exc, input logic eret, input logic br);
    return exc ? RD_EXC : eret ? RD_ERET : br ? RD_BR : RD_NONE;
  endfunction
endpackage

// File: rtl/fetch_pc_perf.sv
// fetch_pc_perf: wrapping counters of granted fetches and fetches blocked by stall or missing grant.
module fetch_pc_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        gnt,
  input  logic        stall,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);
  logic [31:0] fetch_q, fetch_d, stall_q, stall_d;
  always_comb begin
    fetch_d = fetch_q + {31'd0, req & gnt & !stall};
    stall_d = stall_q + {31'd0, req & (stall | !gnt)};
    perf_fetch_cnt = fetch_q;
    perf_stall_cnt = stall_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      fetch_q <= fetch_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: rtl/fetch_pc.sv
// fetch_pc: fetch-stage PC with prioritised redirect, imem handshake and BOOT/RUN/HALT FSM.
// Optional perf counters are built when FETCH_PC_PERF_EN is defined.
module fetch_pc
  import fetch_pc_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEF_RESET_PC),
  parameter logic [ADDR_W-1:0] EXC_VEC     = ADDR_W'(DEF_EXC_VEC),
  parameter int                INSTR_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_redirect,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc,
  input  logic              halt,
  input  logic              imem_gnt,
  output logic              F_req,
  output logic [ADDR_W-1:0] F_pc,
  output logic [ADDR_W-1:0] F_pc8,
  output logic              F_adel,
  output logic [1:0]        F_state
`ifdef FETCH_PC_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);
  localparam logic [ADDR_W-1:0] ALIGN_M = ADDR_W'(INSTR_BYTES - 1);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] LINK    = ADDR_W'(2 * INSTR_BYTES);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, tgt;
  redir_e            redir;
  logic              adv;
  always_comb begin
    F_adel  = |(pc_q & ALIGN_M);
    F_req   = (state_q == ST_RUN) && !F_adel;
    F_pc    = pc_q;
    F_pc8   = pc_q + LINK;
    F_state = state_q;
    redir   = redir_sel(exc_req, eret_req, br_redirect);
    tgt     = (redir == RD_EXC) ? EXC_VEC : (redir == RD_ERET) ? epc : br_target;
    adv     = F_req & imem_gnt & !stall;
    state_d = state_q;
    pc_d    = pc_q;
    // BOOT ignores redirects; otherwise a redirect beats halt and sequential advance
    if (state_q == ST_BOOT) state_d = ST_RUN;
    else if (redir != RD_NONE) begin
      state_d = ST_RUN;
      pc_d    = tgt;
    end else if (state_q == ST_RUN && halt) state_d = ST_HALT;
    else if (adv) pc_d = pc_q + STEP;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end
`ifdef FETCH_PC_PERF_EN
  fetch_pc_perf u_perf (
    .clk            (clk),
    .reset          (reset),
    .req            (F_req),
    .gnt            (imem_gnt),
    .stall          (stall),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );
`endif
endmodule

// File: tb/tb_fetch_pc.sv
// tb_fetch_pc: directed scoreboard bench for fetch_pc (32-bit instance plus a 16-bit wrap instance).
module tb_fetch_pc;
  logic        clk = 0, reset = 0;
  logic        stall = 0, br_redirect = 0, exc_req = 0, eret_req = 0, halt = 0, imem_gnt = 1;
  logic [31:0] br_target = 0, epc = 0;
  logic        F_req, F_adel;
  logic [31:0] F_pc, F_pc8;
  logic [1:0]  F_state;
  logic        br16 = 0;
  logic [15:0] tgt16 = 0;
  logic        F_req16, F_adel16;
  logic [15:0] F_pc16, F_pc816;
  logic [1:0]  F_state16;
`ifdef FETCH_PC_PERF_EN
  logic [31:0] pf, ps, pf16, ps16;
`endif
  int n_cmp = 0, n_err = 0;
  typedef struct {string tag; logic [31:0] pc; logic req; logic [1:0] st;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fetch_pc dut (
    .clk(clk), .reset(reset), .stall(stall), .br_redirect(br_redirect), .br_target(br_target),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc), .halt(halt), .imem_gnt(imem_gnt),
    .F_req(F_req), .F_pc(F_pc), .F_pc8(F_pc8), .F_adel(F_adel), .F_state(F_state)
`ifdef FETCH_PC_PERF_EN
    , .perf_fetch_cnt(pf), .perf_stall_cnt(ps)
`endif
  );

  fetch_pc #(.ADDR_W(16)) u16 (
    .clk(clk), .reset(reset), .stall(1'b0), .br_redirect(br16), .br_target(tgt16),
    .exc_req(1'b0), .eret_req(1'b0), .epc(16'h0000), .halt(1'b0), .imem_gnt(1'b1),
    .F_req(F_req16), .F_pc(F_pc16), .F_pc8(F_pc816), .F_adel(F_adel16), .F_state(F_state16)
`ifdef FETCH_PC_PERF_EN
    , .perf_fetch_cnt(pf16), .perf_stall_cnt(ps16)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] pc, input logic req, input logic [1:0] st);
    exp_t e;
    e.tag = tag; e.pc = pc; e.req = req; e.st = st;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, ".pc"}, F_pc, e.pc);
      chk({e.tag, ".req"}, {31'd0, F_req}, {31'd0, e.req});
      chk({e.tag, ".st"}, {30'd0, F_state}, {30'd0, e.st});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #7;
    push("reset", 32'h3000, 0, 0);
    drain();
    chk("reset.pc8", F_pc8, 32'h3008);
    @(negedge clk);
    reset = 1;
    push("boot_to_run", 32'h3000, 1, 1); tick();
    chk("run.pc8", F_pc8, 32'h3008);
    chk("run.adel", {31'd0, F_adel}, 32'd0);
    push("seq1", 32'h3004, 1, 1); tick();
    push("seq2", 32'h3008, 1, 1); tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin push("stall_hold", 32'h3008, 1, 1); tick(); end
    stall = 0; imem_gnt = 0;
    for (int i = 0; i < 2; i++) begin push("nogrant_hold", 32'h3008, 1, 1); tick(); end
    imem_gnt = 1;
    push("resume", 32'h300C, 1, 1); tick();
    exc_req = 1; eret_req = 1; epc = 32'h3100; br_redirect = 1; br_target = 32'h3200; stall = 1;
    push("exc_prio", 32'h4180, 1, 1); tick();
    exc_req = 0;
    push("eret_prio", 32'h3100, 1, 1); tick();
    eret_req = 0;
    push("branch", 32'h3200, 1, 1); tick();
    stall = 0; br_target = 32'h3202;
    push("misalign", 32'h3202, 0, 1); tick();
    chk("misalign.adel", {31'd0, F_adel}, 32'd1);
    br_redirect = 0;
    push("misalign_hold", 32'h3202, 0, 1); tick();
    chk("misalign_hold.adel", {31'd0, F_adel}, 32'd1);
    br_redirect = 1; br_target = 32'h3300;
    push("realign", 32'h3300, 1, 1); tick();
    chk("realign.adel", {31'd0, F_adel}, 32'd0);
    br_redirect = 0; halt = 1;
    push("halt_in", 32'h3300, 0, 2); tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 5) halt = 0;
      push("halt_hold", 32'h3300, 0, 2); tick();
    end
    exc_req = 1;
    push("halt_exc", 32'h4180, 1, 1); tick();
    exc_req = 0;
    push("after_exc", 32'h4184, 1, 1); tick();
    halt = 1; br_redirect = 1; br_target = 32'h3400;
    push("halt_vs_br", 32'h3400, 1, 1); tick();
    halt = 0; br_redirect = 0;
    push("after_br", 32'h3404, 1, 1); tick();
    halt = 1;
    push("halt2", 32'h3404, 0, 2); tick();
    halt = 0; eret_req = 1; epc = 32'h3100; br_redirect = 1; br_target = 32'h3200;
    push("halt_eret", 32'h3100, 1, 1); tick();
    eret_req = 0; br_redirect = 0;
    br16 = 1; tgt16 = 16'hFFFC;
    push("seq_a", 32'h3104, 1, 1); tick();
    chk("w16.pre", {16'd0, F_pc16}, 32'h0000FFFC);
    br16 = 0;
    push("seq_b", 32'h3108, 1, 1); tick();
    chk("w16.wrap", {16'd0, F_pc16}, 32'h00000000);
    chk("w16.req", {31'd0, F_req16}, 32'd1);
    #3;
    reset = 0;
    #1;
    push("async_rst", 32'h3000, 0, 0);
    drain();
    chk("async_rst.pc16", {16'd0, F_pc16}, 32'h00003000);
`ifdef FETCH_PC_PERF_EN
    chk("perf.fetch", pf, 32'd0);
    chk("perf.stall", ps, 32'd0);
`endif
    @(negedge clk);
    reset = 1;
    push("rerun", 32'h3000, 1, 1); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_pc.md
Name: fetch_pc

Overview:
- Parametrised fetch-stage program counter for the pipelined MIPS core. It replaces the fixed 32-bit stall-only PC register.
- Adds the following over that register:
  - prioritised redirect (exception, eret, branch)
  - an instruction-memory request/grant handshake
  - a boot/run/halt state machine
  - misaligned-fetch detection
- Sits between the NPC/redirect logic and instruction memory; its outputs feed the F/D pipeline register.

Parameters:
ADDR_W, 32, PC width in bits
RESET_PC, 32'h0000_3000, PC value loaded by reset
EXC_VEC, 32'h0000_4180, exception handler entry address
INSTR_BYTES, 4, byte increment per sequential fetch (power of two)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  hazard stall from the decode stage; blocks sequential advance only
br_redirect  in  1  branch/jump resolved taken, load br_target
br_target  in  ADDR_W  branch/jump destination
exc_req  in  1  exception/interrupt taken, load EXC_VEC
eret_req  in  1  eret executed, load epc
epc  in  ADDR_W  return address supplied by CP0
halt  in  1  stop fetching at the next edge
imem_gnt  in  1  instruction memory accepts the current request this cycle
F_req  out  1  fetch request valid
F_pc  out  ADDR_W  current fetch address
F_pc8  out  ADDR_W  F_pc + 2*INSTR_BYTES (link address)
F_adel  out  1  F_pc not aligned to INSTR_BYTES
F_state  out  2  FSM state: 0 BOOT, 1 RUN, 2 HALT

Behaviour:
- Reset (reset==0, asynchronous, any time including mid-fetch):
  - state=BOOT, F_pc=RESET_PC.
  - F_req=0 while in reset.
  - F_pc8 and F_adel are combinational from F_pc.
- BOOT: F_req=0; always moves to RUN on the first clk edge after reset deasserts. Redirects are ignored in BOOT.
- RUN:
  - F_req = !F_adel.
  - On a clk edge, next PC is chosen by priority:
    1. exc_req -> EXC_VEC
    2. eret_req -> epc
    3. br_redirect -> br_target
    4. F_req & imem_gnt & !stall -> F_pc + INSTR_BYTES
    5. otherwise hold
- Redirects (exc_req, eret_req, br_redirect) take effect regardless of stall and imem_gnt. A request not granted in the cycle a redirect arrives is abandoned; no replay.
- Sequential increment wraps modulo 2^ADDR_W (e.g. all-ones minus 3 + 4 -> 0). It is not flagged.
- Misalignment:
  - F_adel = (F_pc mod INSTR_BYTES) != 0.
  - While F_adel=1, F_req=0 and the PC holds until a redirect.
  - A misaligned br_target or epc is loaded as-is and raises F_adel the next cycle.
- RUN -> HALT on a clk edge when halt=1 and no redirect is present; the PC holds.
- RUN with halt=1 and a redirect present: the redirect is taken and the state stays RUN.
- HALT:
  - F_req=0, PC held; stall and imem_gnt are ignored.
  - Any redirect loads its target (same priority order) and returns to RUN on the same edge.
  - halt is ignored while in HALT.
- Latency: a redirect asserted in cycle n gives the new F_pc, with F_req valid, in cycle n+1.
- All outputs are registered except F_pc8, F_adel and F_req, which are combinational from state and F_pc.

Optional Feature:
FETCH_PC_PERF_EN:
- Defined: adds two outputs.
  - perf_fetch_cnt (32-bit): increments on every cycle where F_req & imem_gnt & !stall.
  - perf_stall_cnt (32-bit): increments on every RUN cycle where F_req & (stall | !imem_gnt).
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pc_pkg holds:
  - state encoding constants ST_BOOT=2'd0, ST_RUN=2'd1, ST_HALT=2'd2
  - default RESET_PC and EXC_VEC values
  - redirect priority encoding
- One sub-module, fetch_pc_perf, containing the two counters. It is instantiated only under FETCH_PC_PERF_EN.
- The next-PC mux and FSM stay in fetch_pc.

Test Plan:
- Reset release with imem_gnt=1, stall=0, defaults:
  - Cycle 0: F_state=BOOT, F_req=0, F_pc=0x3000.
  - Then RUN with F_pc sequence 0x3000, 0x3004, 0x3008; F_pc8=0x3008 when F_pc=0x3000.
- Hold conditions: stall=1 for 3 cycles, then imem_gnt=0 for 2 cycles -> F_pc held at 0x3008 for 5 cycles with F_req=1, then resumes at 0x300C.
- Simultaneous exc_req, eret_req (epc=0x3100), br_redirect (target 0x3200) with stall=1 -> next F_pc=0x4180. Then eret plus branch -> 0x3100. Then branch alone -> 0x3200.
- Misalignment and wrap:
  - br_target=0x3202 -> F_adel=1, F_req=0, PC held; a later br_redirect to 0x3300 clears F_adel.
  - With ADDR_W=16: F_pc=0xFFFC advances to 0x0000.
- halt=1 in RUN -> F_state=HALT, F_req=0, PC frozen across 10 cycles with gnt=1. Then exc_req -> F_pc=0x4180 and RUN next cycle.
- Async reset mid-run at a non-edge time -> F_pc=0x3000, F_req=0, F_state=BOOT immediately. With FETCH_PC_PERF_EN, both counters read 0.
